// File: rtl/clap_pattern_ctrl.sv
// Clap pattern sequencer: groups clap pulses into patterns using a post-clap
// lockout and an inter-clap gap timeout, and reports each finished pattern
// through a valid/ready handshake.
module clap_pattern_ctrl #(
    parameter int unsigned LOCKOUT_CYC = 5_000_000,
    parameter int unsigned GAP_CYC     = 50_000_000,
    parameter int unsigned MAX_CLAPS   = 4,
    parameter int unsigned TMR_W       = 27
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clap_i,
    output logic       pattern_valid_o,
    output logic [2:0] pattern_cnt_o,
    input  logic       pattern_ready_i,
    output logic       busy_o,
    output logic       dropped_o,
    output logic [1:0] state_o
);

    localparam int unsigned CNT_W = 3;
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CLAPS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCKOUT  = 2'd1,
        ST_WAIT_GAP = 2'd2,
        ST_REPORT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dropped_d;
    logic               valid_q;
    logic [CNT_W-1:0]   pcnt_q;
    logic               busy_q;
    logic               dropped_q;

    // Next-state, timer and clap-count logic.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        dropped_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_i && clap_i) begin
                    cnt_d   = CNT_ONE;
                    tmr_d   = '0;
                    // A one-clap pattern is complete as soon as it starts.
                    state_d = (CNT_MAX == CNT_ONE) ? ST_REPORT : ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else if (tmr_q == LOCK_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_GAP: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else if (clap_i) begin
                    // A clap on the expiry cycle wins over the timeout.
                    cnt_d   = cnt_q + CNT_ONE;
                    tmr_d   = '0;
                    state_d = ((cnt_q + CNT_ONE) == CNT_MAX) ? ST_REPORT : ST_LOCKOUT;
                end else if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_REPORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_REPORT: begin
                // Report is held regardless of en_i; claps here are lost.
                dropped_d = clap_i;
                if (pattern_ready_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // State, timer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers, loaded from the next-state values so they track state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            pcnt_q    <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            valid_q   <= (state_d == ST_REPORT);
            pcnt_q    <= (state_d == ST_REPORT) ? cnt_d : '0;
            busy_q    <= (state_d != ST_IDLE);
            dropped_q <= dropped_d;
        end
    end

    assign pattern_valid_o = valid_q;
    assign pattern_cnt_o   = pcnt_q;
    assign busy_o          = busy_q;
    assign dropped_o       = dropped_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_clap_pattern_ctrl.sv
// Bench for clap_pattern_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a timestamp-based pattern model.
module tb_clap_pattern_ctrl;

    localparam int unsigned L    = 4;
    localparam int unsigned G    = 10;
    localparam int unsigned MAXC = 3;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       clap_i;
    logic       pattern_ready_i;
    logic       pattern_valid_o;
    logic [2:0] pattern_cnt_o;
    logic       busy_o;
    logic       dropped_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // Model: a pattern is described by the cycle of its last accepted clap.
    int cyc    = 0;
    int m_t0   = 0;
    int m_cnt  = 0;
    bit m_rep  = 1'b0;
    bit m_drop = 1'b0;

    clap_pattern_ctrl #(
        .LOCKOUT_CYC(L), .GAP_CYC(G), .MAX_CLAPS(MAXC), .TMR_W(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .clap_i(clap_i),
        .pattern_valid_o(pattern_valid_o), .pattern_cnt_o(pattern_cnt_o),
        .pattern_ready_i(pattern_ready_i), .busy_o(busy_o),
        .dropped_o(dropped_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // 0 idle, 1 lockout, 2 gap wait, 3 report, from time since the last clap.
    function automatic int m_phase();
        if (m_rep) return 3;
        if (m_cnt == 0) return 0;
        if (cyc - m_t0 <= int'(L)) return 1;
        return 2;
    endfunction

    task automatic m_reset();
        m_rep = 1'b0; m_cnt = 0; m_drop = 1'b0; m_t0 = 0;
    endtask

    task automatic m_update(input bit en, input bit clap, input bit rdy);
        int ph;
        bit drop_nx;
        ph = m_phase();
        drop_nx = 1'b0;
        case (ph)
            0: if (en && clap) begin
                m_cnt = 1; m_t0 = cyc;
                if (MAXC == 1) m_rep = 1'b1;
            end
            1: if (!en) m_cnt = 0;
            2: begin
                if (!en) m_cnt = 0;
                else if (clap) begin
                    m_cnt++;
                    if (m_cnt == int'(MAXC)) m_rep = 1'b1;
                    else m_t0 = cyc;
                end else if (cyc - m_t0 == int'(L + G)) m_rep = 1'b1;
            end
            default: begin
                drop_nx = clap;
                if (rdy) begin m_rep = 1'b0; m_cnt = 0; end
            end
        endcase
        m_drop = drop_nx;
    endtask

    // One cycle: check outputs against model, apply inputs, advance model.
    task automatic step(input bit en, input bit clap, input bit rdy);
        int ph;
        @(negedge clk);
        ph = m_phase();
        chk("state", state_o, ph);
        chk("valid", pattern_valid_o, (ph == 3));
        chk("cnt", pattern_cnt_o, (ph == 3) ? m_cnt : 0);
        chk("busy", busy_o, (ph != 0));
        chk("dropped", dropped_o, m_drop);
        en_i = en; clap_i = clap; pattern_ready_i = rdy;
        m_update(en, clap, rdy);
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, pattern_valid_o, 0);
        chk({tag, "_cnt"}, pattern_cnt_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_dropped"}, dropped_o, 0);
        chk({tag, "_state"}, state_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; clap_i = 1'b0; pattern_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_ni = 1'b1; en_i = 1'b1;
        m_reset();

        // Single clap: report from cycle 15, accepted at 17, idle at 18.
        step(1, 1, 0);
        step(1, 0, 0);
        chk("single_lockout", state_o, 1);
        repeat (13) step(1, 0, 0);
        chk("single_gap_end", state_o, 2);
        step(1, 0, 0);
        chk("single_report", state_o, 3);
        chk("single_cnt", pattern_cnt_o, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("single_idle", state_o, 0);
        repeat (2) step(1, 0, 0);

        // Double clap: second lockout 8..11, gap 12..21, report at 22.
        step(1, 1, 0);
        repeat (6) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        chk("double_lockout", state_o, 1);
        repeat (13) step(1, 0, 0);
        chk("double_gap_end", state_o, 2);
        step(1, 0, 0);
        chk("double_report", state_o, 3);
        chk("double_cnt", pattern_cnt_o, 2);
        step(1, 0, 1);
        repeat (2) step(1, 0, 0);

        // Clap during lockout is ignored silently.
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (12) step(1, 0, 0);
        step(1, 0, 0);
        chk("lock_report", state_o, 3);
        chk("lock_cnt", pattern_cnt_o, 1);
        step(1, 0, 1);
        repeat (2) step(1, 0, 0);

        // Max claps terminate at once: claps 0, 5, 10, report at 11.
        step(1, 1, 0);
        repeat (4) step(1, 0, 0);
        step(1, 1, 0);
        chk("max_gap_start", state_o, 2);
        repeat (4) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        chk("max_report", state_o, 3);
        chk("max_cnt", pattern_cnt_o, 3);
        step(1, 0, 1);
        repeat (2) step(1, 0, 0);

        // Backpressure: dropped clap, en_i low while reporting, clap on transfer.
        step(1, 1, 0);
        repeat (15) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        chk("bp_dropped", dropped_o, 1);
        chk("bp_cnt", pattern_cnt_o, 1);
        step(0, 0, 0);
        chk("bp_dropped_once", dropped_o, 0);
        repeat (5) step(0, 0, 0);
        chk("bp_valid_held", pattern_valid_o, 1);
        step(0, 1, 1);
        step(1, 0, 0);
        chk("bp_idle", state_o, 0);
        chk("bp_xfer_dropped", dropped_o, 1);
        repeat (2) step(1, 0, 0);

        // Abort: en_i low at cycle 6, idle at 7, then a fresh single clap.
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        chk("abort_idle", state_o, 0);
        repeat (20) step(1, 0, 0);
        chk("abort_no_valid", pattern_valid_o, 0);
        step(1, 1, 0);
        repeat (15) step(1, 0, 0);
        chk("abort_next_cnt", pattern_cnt_o, 1);
        step(1, 0, 1);
        repeat (2) step(1, 0, 0);

        // Async reset between edges while in gap wait.
        step(1, 1, 0);
        repeat (7) step(1, 0, 0);
        #2 rst_ni = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst_ni = 1'b1; en_i = 1'b1; clap_i = 1'b0; pattern_ready_i = 1'b0;
        m_reset();
        step(1, 0, 0);

        // Clap on the gap-expiry cycle is counted and re-enters lockout.
        step(1, 1, 0);
        repeat (13) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        chk("prio_lockout", state_o, 1);
        chk("prio_no_valid", pattern_valid_o, 0);
        repeat (20) step(1, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 30));
        end
        step(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
